// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared constants for the synchronous FIFO controller and its sibling
// dual-port RAM: default geometry and the address/pointer width helpers.
package sync_fifo_ctrl_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;

    // RAM address width for a power-of-two depth.
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : sync_fifo_ctrl_pkg

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller. Drives an external dual-port RAM as a
// circular buffer and derives every status output from the registered
// read/write pointers only.
//
// Handshake: a write is accepted when winc=1 and wfull=0 in the same cycle;
// a read is accepted when rinc=1 and rempty=0. Both flags are evaluated
// before the clock edge. An accepted read returns its word on rdata with
// rvalid=1 exactly one cycle later. Rejected requests change nothing except
// the sticky overflow/underflow flags.
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    localparam int ADDR_W  = addr_width(DEPTH),
    localparam int PTR_W   = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              winc,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rinc,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic              wfull,
    output logic              rempty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   fifo_cnt,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr,
    output logic              ram_wenc,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [WIDTH-1:0]  ram_wdata,
    output logic              ram_renc,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [WIDTH-1:0]  ram_rdata
);

    localparam logic [PTR_W-1:0] AF_THR = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LEVEL);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             rvalid_q, rvalid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [PTR_W-1:0] cnt;
    logic             full;
    logic             empty;
    logic             wacc;
    logic             racc;

    // Status from registered pointers; the wrap bit separates full from empty.
    always_comb begin
        cnt   = wptr_q - rptr_q;
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    end

    // Request acceptance and next-state: pointers advance only on accepted
    // transfers; a sticky flag set beats a same-cycle clear.
    always_comb begin
        wacc     = winc & ~full;
        racc     = rinc & ~empty;
        wptr_d   = wptr_q + {{ADDR_W{1'b0}}, wacc};
        rptr_d   = rptr_q + {{ADDR_W{1'b0}}, racc};
        rvalid_d = racc;
        ovf_d    = (winc & full)  | (ovf_q & ~err_clr);
        unf_d    = (rinc & empty) | (unf_q & ~err_clr);
    end

    // State registers with asynchronous reset; a pending rvalid is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Output drive: RAM strobes are combinational from the accept terms.
    always_comb begin
        ram_wenc     = wacc;
        ram_waddr    = wptr_q[ADDR_W-1:0];
        ram_wdata    = wdata;
        ram_renc     = racc;
        ram_raddr    = rptr_q[ADDR_W-1:0];
        rdata        = ram_rdata;
        rvalid       = rvalid_q;
        wfull        = full;
        rempty       = empty;
        fifo_cnt     = cnt;
        almost_full  = (cnt >= AF_THR);
        almost_empty = (cnt <= AE_THR);
        overflow     = ovf_q;
        underflow    = unf_q;
    end

endmodule : sync_fifo_ctrl

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences an external dual_port_RAM instance (both RAM clocks tied to clk) as a circular buffer. It owns the read and write pointers, generates the RAM enables and addresses, and reports the following status:
- full and empty
- almost-full and almost-empty
- occupancy
- sticky overflow and underflow errors

The parent instantiates this block and dual_port_RAM side by side. The parent connects the ram_* ports directly.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two and ≥ 2; ADDR_W = $clog2(DEPTH).
- WIDTH, 8, data width in bits.
- AF_LEVEL, DEPTH-4, almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL.

Ports:
- clk  in  1  single clock for the controller and both RAM ports.
- rst_n  in  1  asynchronous active-low reset.
- winc  in  1  write request.
- wdata  in  WIDTH  write data.
- rinc  in  1  read request.
- rdata  out  WIDTH  read data; valid when rvalid=1.
- rvalid  out  1  read data valid, one cycle after an accepted read.
- wfull  out  1  FIFO full.
- rempty  out  1  FIFO empty.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- fifo_cnt  out  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- err_clr  in  1  synchronous clear of overflow and underflow.
- ram_wenc  out  1  RAM write enable.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_wdata  out  WIDTH  RAM write data.
- ram_renc  out  1  RAM read enable.
- ram_raddr  out  ADDR_W  RAM read address.
- ram_rdata  in  WIDTH  RAM read data, registered inside the RAM.

Behaviour:
- Reset is asynchronous on the falling edge of rst_n; the block leaves reset on the first clk edge with rst_n=1.
- Reset values:
  - wptr = rptr = 0; fifo_cnt = 0.
  - rempty = 1, wfull = 0.
  - almost_empty = 1, almost_full = 0.
  - rvalid = 0, overflow = 0, underflow = 0.
- Pointers are ADDR_W+1 bits wide; the MSB is the wrap bit.
  - RAM addresses use the low ADDR_W bits.
  - Pointers wrap naturally modulo 2·DEPTH.
- Status is a function of the registered pointers only; there is no combinational path from winc/rinc to the status outputs.
  - fifo_cnt = wptr − rptr (modulo 2^(ADDR_W+1)).
  - rempty = (wptr == rptr).
  - wfull = (MSBs differ) and (low bits equal).
  - almost_full and almost_empty compare fifo_cnt against the thresholds.
- Write accept: wacc = winc & ~wfull.
  - ram_wenc = wacc, combinational.
  - ram_waddr = wptr[ADDR_W-1:0]; ram_wdata = wdata.
  - wptr increments at the clock edge.
- Read accept: racc = rinc & ~rempty.
  - ram_renc = racc; ram_raddr = rptr[ADDR_W-1:0].
  - rptr increments at the clock edge.
  - rvalid is racc registered, so latency is one cycle.
  - rdata = ram_rdata, passed through.
- Simultaneous accepted write and read: count is unchanged and both pointers advance.
- Full with winc and rinc both high: the read is accepted and the write is rejected, because wfull is evaluated pre-edge. overflow sets.
- Empty with winc and rinc both high: the write is accepted and the read is rejected. There is no fall-through bypass. underflow sets, and rvalid = 0 next cycle.
- Rejected requests have no effect on the pointers or the RAM.
- overflow sets on winc & wfull; underflow sets on rinc & rempty.
  - Both are cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-operation: all state returns to reset values immediately. RAM contents are don't-care, and a pending rvalid is dropped.

Decomposition:
- Shared package/header: the ADDR_W derivation ($clog2(DEPTH)), the pointer width ADDR_W+1, and the default DEPTH and WIDTH constants shared with dual_port_RAM.
- No sub-module inside the controller. The RAM is a sibling instance in the parent; the bench wraps both in a test top.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F with no reads -> wfull=1 after the 16th edge, fifo_cnt=16, almost_full first asserts at count 12. A 17th winc -> ram_wenc=0 and overflow=1.
- 16 reads after the fill -> rdata sequence 0x00..0x0F, each with rvalid one cycle after rinc. rempty=1 after the last read; almost_empty first asserts at count 4. An extra rinc -> underflow=1, rvalid=0.
- Wrap-around: repeat 40 writes and 40 reads interleaved at occupancy 3 -> data order preserved across pointer wrap, and fifo_cnt stays at 3 during steady simultaneous traffic.
- Full with winc=rinc=1 -> read returns the oldest word, fifo_cnt stays 16 minus 1 = 15 next cycle, overflow=1. Empty with winc=rinc=1 -> fifo_cnt=1, no rvalid, underflow=1.
- err_clr pulse -> overflow and underflow both 0. err_clr coincident with a fresh overflowing write -> overflow stays 1.
- Assert rst_n=0 at fifo_cnt=7 while rinc is active -> all outputs return to reset values asynchronously, rvalid=0. The first write after release goes to ram_waddr=0.
